// File: rtl/alu_pkg.sv
// ALU op / branch encodings and arbiter FSM states shared by the ALU sharing logic.
package alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_SLL   = 3'd4;
  localparam logic [2:0] ALU_SRA   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;
  localparam logic [2:0] ALU_AUIPC = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest distance from ptr among active requests wins.
// The pointer register lives in the parent; en=0 forces an all-zero grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win_idx
);

  int  w_best;
  int  w_dist;
  logic w_found;

  always_comb begin
    w_best  = NREQ;
    w_dist  = 0;
    win_idx = '0;
    grant   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
      if (en && req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        win_idx = IDW'(i);
      end
    end
    w_found = (w_best < NREQ);
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = w_found && (win_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU: accept -> drive ALU one cycle -> hold response.
// Optional perf counters when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_in1,
  input  logic [NREQ*XLEN-1:0] req_in2,
  input  logic [NREQ*3-1:0]    req_aluctr,
  input  logic [NREQ*3-1:0]    req_funct3,
  input  logic [NREQ*XLEN-1:0] req_pc,
  input  logic [NREQ-1:0]      req_branch,
  input  logic [NREQ-1:0]      req_jumpi,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  output logic [XLEN-1:0]      alu_pc,
  output logic [2:0]           alu_aluctr,
  output logic [2:0]           alu_funct3,
  output logic                 alu_branch,
  output logic                 alu_jumpi,
  input  logic [XLEN-1:0]      alu_out,
  input  logic                 alu_jump,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
`ifdef ALU_ARB_PERF_EN
  output logic [NREQ*32-1:0]   perf_grant_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic                 rsp_jump
);

  arb_state_t r_state, w_state_nxt;

  logic [IDW-1:0]  r_ptr, r_issue_id, w_win, w_ptr_nxt;
  logic [NREQ-1:0] w_grant;
  logic            w_arb_en, w_accept, w_capture;

  logic [XLEN-1:0] r_alu_in1, r_alu_in2, r_alu_pc, w_sel_in1, w_sel_in2, w_sel_pc;
  logic [2:0]      r_alu_aluctr, r_alu_funct3, w_sel_aluctr, w_sel_funct3;
  logic            r_alu_branch, r_alu_jumpi, w_sel_branch, w_sel_jumpi;

  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_jump;

  // Arbitration is only live in cycles that can actually take a new op.
  assign w_arb_en = !rst && !flush &&
                    ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .grant   (w_grant),
    .win_idx (w_win)
  );

  assign w_accept  = |w_grant;
  assign req_ready = w_grant;
  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : (w_win + IDW'(1));

  always_comb begin
    w_sel_in1    = '0;
    w_sel_in2    = '0;
    w_sel_pc     = '0;
    w_sel_aluctr = '0;
    w_sel_funct3 = '0;
    w_sel_branch = 1'b0;
    w_sel_jumpi  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_in1    = req_in1[i*XLEN +: XLEN];
        w_sel_in2    = req_in2[i*XLEN +: XLEN];
        w_sel_pc     = req_pc[i*XLEN +: XLEN];
        w_sel_aluctr = req_aluctr[i*3 +: 3];
        w_sel_funct3 = req_funct3[i*3 +: 3];
        w_sel_branch = req_branch[i];
        w_sel_jumpi  = req_jumpi[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush)          w_state_nxt = ST_IDLE;
        else if (rsp_ready) w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ALU inputs change only on accept so the ALU sees no toggling while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= '0;
      r_issue_id   <= '0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_alu_pc     <= '0;
      r_alu_aluctr <= '0;
      r_alu_funct3 <= '0;
      r_alu_branch <= 1'b0;
      r_alu_jumpi  <= 1'b0;
    end else if (w_accept) begin
      r_ptr        <= w_ptr_nxt;
      r_issue_id   <= w_win;
      r_alu_in1    <= w_sel_in1;
      r_alu_in2    <= w_sel_in2;
      r_alu_pc     <= w_sel_pc;
      r_alu_aluctr <= w_sel_aluctr;
      r_alu_funct3 <= w_sel_funct3;
      r_alu_branch <= w_sel_branch;
      r_alu_jumpi  <= w_sel_jumpi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_jump <= 1'b0;
    end else if (w_capture) begin
      r_rsp_id   <= r_issue_id;
      r_rsp_data <= alu_out;
      r_rsp_jump <= alu_jump;
    end
  end

  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_pc     = r_alu_pc;
  assign alu_aluctr = r_alu_aluctr;
  assign alu_funct3 = r_alu_funct3;
  assign alu_branch = r_alu_branch;
  assign alu_jumpi  = r_alu_jumpi;

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_jump   = r_rsp_jump;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_grant_cnt [NREQ];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
      if (rsp_valid && !rsp_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) perf_grant_cnt[i*32 +: 32] = r_grant_cnt[i];
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
